uart_tx_arbiter: RTL

- Round-robin arbiter that shares the single UART byte transmitter between N_REQ byte producers (debug console, status reporter, etc.).
- Each requester presents one byte with a level request. The arbiter grants one requester, latches its byte, and drives the transmitter's trigger/data inputs.
- It holds trigger until the transmitter reports busy, then waits for busy to clear before granting again.
- It sits directly in front of the transmitter's trigger, q_in and busy pins. The transmitter keeps its own baud clk_en.

---
 rtl/uart_tx_arbiter_if.sv | 25 ++
 rtl/uart_tx_arbiter.sv | 114 +++++++++++
 2 files changed

// File: rtl/uart_tx_arbiter_if.sv
// Requester and transmitter-side signals of the UART transmit arbiter.
// The master modport is the arbiter. The slave modport is the requesters and the transmitter.
interface uart_tx_arbiter_if #(
  parameter int N_REQ = 4,
  parameter int IDX_W = 2
);
  logic [N_REQ-1:0]   req;
  logic [8*N_REQ-1:0] req_data;
  logic [N_REQ-1:0]   ack;
  logic [IDX_W-1:0]   grant_idx;
  logic               arb_busy;
  logic               tx_trigger;
  logic [7:0]         tx_data;
  logic               tx_busy;

  modport master (
    input  req, req_data, tx_busy,
    output ack, grant_idx, arb_busy, tx_trigger, tx_data
  );

  modport slave (
    output req, req_data, tx_busy,
    input  ack, grant_idx, arb_busy, tx_trigger, tx_data
  );
endinterface

// File: rtl/uart_tx_arbiter.sv
// Round-robin arbiter that shares one UART byte transmitter among N_REQ producers.
// It latches the winner's byte, holds trigger until the transmitter goes busy, and then waits for idle.
module uart_tx_arbiter #(
  parameter int N_REQ = 4,
  parameter int IDX_W = 2
) (
  input  logic              clk,
  input  logic              rst_n,
  uart_tx_arbiter_if.master bus
);
  localparam int SLOTS = 1 << IDX_W;
  localparam logic [IDX_W-1:0] LAST_INIT = IDX_W'(N_REQ - 1);

  typedef enum logic [1:0] {IDLE = 2'd0, ARM = 2'd1, SEND = 2'd2} state_t;

  state_t             state_reg, state_next;
  logic [IDX_W-1:0]   last_reg, last_next;
  logic [IDX_W-1:0]   grant_reg, grant_next;
  logic [N_REQ-1:0]   ack_reg, ack_next;
  logic               trig_reg, trig_next;
  logic [7:0]         data_reg, data_next;

  logic [SLOTS-1:0]   req_pad;
  logic [7:0]         req_bytes [SLOTS];
  logic [IDX_W-1:0]   cand;
  logic [IDX_W-1:0]   winner;
  logic               found;

  // Pad the request and byte vectors to 2**IDX_W so a grant index can address them directly.
  generate
    for (genvar gi = 0; gi < SLOTS; gi++) begin : g_slot
      if (gi < N_REQ) begin : g_used
        assign req_pad[gi]   = bus.req[gi];
        assign req_bytes[gi] = bus.req_data[8*gi +: 8];
      end else begin : g_pad
        assign req_pad[gi]   = 1'b0;
        assign req_bytes[gi] = 8'h00;
      end
    end
  endgenerate

  // The search starts at the requester after the last one served and wraps around.
  always_comb begin
    found  = 1'b0;
    winner = last_reg;
    cand   = last_reg;
    for (int k = 1; k <= N_REQ; k++) begin
      cand = IDX_W'((int'(last_reg) + k) % N_REQ);
      if (!found && req_pad[cand]) begin
        found  = 1'b1;
        winner = cand;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_reg <= IDLE;
      last_reg  <= LAST_INIT;
      grant_reg <= '0;
      ack_reg   <= '0;
      trig_reg  <= 1'b0;
      data_reg  <= 8'h00;
    end else begin
      state_reg <= state_next;
      last_reg  <= last_next;
      grant_reg <= grant_next;
      ack_reg   <= ack_next;
      trig_reg  <= trig_next;
      data_reg  <= data_next;
    end
  end

  always_comb begin
    state_next = state_reg;
    last_next  = last_reg;
    grant_next = grant_reg;
    ack_next   = '0;
    trig_next  = 1'b0;
    data_next  = data_reg;
    unique case (state_reg)
      IDLE: begin
        // A byte left over from before a reset may still be on the line, so wait for idle.
        if (found && !bus.tx_busy) begin
          data_next  = req_bytes[winner];
          grant_next = winner;
          ack_next   = N_REQ'(1) << winner;
          trig_next  = 1'b1;
          state_next = ARM;
        end
      end
      ARM: begin
        trig_next = 1'b1;
        if (bus.tx_busy) begin
          trig_next  = 1'b0;
          state_next = SEND;
        end
      end
      SEND: begin
        if (!bus.tx_busy) begin
          last_next  = grant_reg;
          state_next = IDLE;
        end
      end
      default: state_next = IDLE;
    endcase
  end

  assign bus.ack        = ack_reg;
  assign bus.grant_idx  = grant_reg;
  assign bus.tx_trigger = trig_reg;
  assign bus.tx_data    = data_reg;
  assign bus.arb_busy   = (state_reg != IDLE);
endmodule
